cpu_clk_ctrl: RTL and testbench
===============================

// Module: cpu_clk_ctrl
// PURPOSE
//  Run/step/halt sequencer for the multi-cycle CPU clock on the board.
//  It replaces a free-running divided clock with a single-cycle clock-enable (cpu_ce) on clk.
//  The CPU advances one micro-step per cpu_ce. Supported modes: free-run at a switch-selected
//  divide ratio, single-step from a push button, and stop on CPU halt.
//  clk_sys toggles per enable for LED/7-seg visibility.
// PARAMETERS
//  DIV0        10000     clk cycles per cpu_ce, div_sel=0 (must be >=1)
//  DIV1        1000000   clk cycles per cpu_ce, div_sel=1
//  DIV2        25000000  clk cycles per cpu_ce, div_sel=2
//  DIV3        1         clk cycles per cpu_ce, div_sel=3 (full speed)
//  CNT_W       26        divide counter width; every DIVn-1 must fit
//  DEB_CYCLES  1000000   cycles step_btn must be stable to register (10 ms @100 MHz)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  run_sw     in   1   1 = free-run request (static switch, pre-synchronised)
//  step_btn   in   1   raw push button, asynchronous, bouncy
//  div_sel    in   2   divide-ratio select (DIV0..DIV3)
//  cpu_halt   in   1   CPU executed halt; level, held until CPU reset
//  cpu_ce     out  1   one-clk-wide CPU clock enable, registered
//  clk_sys    out  1   toggles on every cpu_ce (display only, never used as a clock)
//  state      out  2   00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//  cycle_cnt  out  32  number of cpu_ce pulses issued; wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: state=IDLE, cpu_ce=0, clk_sys=0, div counter=0, cycle_cnt=0, debouncer cleared (level 0).
//  step_btn: 2-FF synchroniser -> debouncer -> rising edge of debounced level = step_pulse (1 clk).
//  Transition priority in every state: cpu_halt > run_sw > step_pulse.
//  IDLE:   cpu_halt -> HALTED; else run_sw -> RUN (cnt=0); else step_pulse -> STEP.
//  STEP:   cpu_ce=1 for exactly this cycle; unconditionally -> IDLE next cycle.
//  RUN:    cpu_halt -> HALTED, no cpu_ce. Else !run_sw -> IDLE, cnt=0. Else if cnt>=DIVsel-1 ->
//          cpu_ce=1 next cycle, cnt=0. Else cnt++.
//          First cpu_ce is DIVsel cycles after the first RUN cycle; then one every DIVsel cycles.
//  HALTED: no cpu_ce; step_pulse ignored; -> IDLE only when cpu_halt=0 AND run_sw=0.
//  div_sel change mid-count takes effect immediately. Compare is >=, so a cnt already past
//   the new limit fires cpu_ce next cycle and clears cnt; no wrap through 2^CNT_W.
//  DIVsel=1: cpu_ce high every cycle while in RUN.
//  cpu_ce and state are registered together: cpu_ce=1 in the same cycle as state STEP or
//   one cycle after cnt hit in RUN.
//  On each cpu_ce: clk_sys inverts and cycle_cnt++ (modulo 2^32).
//  step_pulse in RUN/HALTED is discarded, not queued. A press held across RUN->IDLE makes
//   no step (edge already consumed).
//  Async reset mid-pulse drops cpu_ce immediately. No pending step survives reset.
// STRUCTURE
//  Shared header clk_ctrl_defs.vh: state encodings (ST_IDLE/RUN/STEP/HALTED), DIV defaults.
//  Sub-module btn_debounce (synchroniser + DEB_CYCLES stability counter + rise-edge pulse,
//   params DEB_CYCLES; ports clk, rst_n, btn_raw, level, rise).
//  Top: 4-state FSM, divide counter with mux on div_sel, clk_sys/cycle_cnt registers.
// TESTING  (DIV0=4, DIV1=8, DIV2=2, DIV3=1, DEB_CYCLES=3)
//  Reset + run_sw=1, div_sel=0 -> first cpu_ce 4 clks after RUN entered, then every 4;
//   100 clks -> cycle_cnt=24.
//  Bouncy step_btn (1-0-1 glitches <3 clks, then stable 1) in IDLE -> exactly one STEP cycle,
//   one cpu_ce, clk_sys toggles once.
//  RUN div_sel=1 with cnt=6, switch to div_sel=2 -> cpu_ce next clk; then every 2 clks.
//  cpu_halt=1 in RUN on the cycle cnt hits -> no cpu_ce, HALTED; step presses ignored; drop
//   halt with run_sw=1 -> stays HALTED; run_sw=0 -> IDLE.
//  div_sel=3 RUN -> cpu_ce constant 1; preload cycle_cnt near 2^32-1 (force) -> wraps to 0.
//  rst_n low while cpu_ce=1 in RUN -> all outputs to reset values asynchronously; after
//   release state=IDLE, no cpu_ce.

Source files
------------

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable sequencer: state encodings and
// default divide / debounce parameters.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } clk_state_t;

  localparam int unsigned DIV0_DEF       = 10000;
  localparam int unsigned DIV1_DEF       = 1000000;
  localparam int unsigned DIV2_DEF       = 25000000;
  localparam int unsigned DIV3_DEF       = 1;
  localparam int unsigned CNT_W_DEF      = 26;
  localparam int unsigned DEB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Board/CPU-side signal bundle of the clock sequencer. The slave modport is the
// sequencer itself; the master modport is the board/CPU side driving it.
interface cpu_clk_ctrl_if;
  logic        run_sw;
  logic        step_btn;
  logic [1:0]  div_sel;
  logic        cpu_halt;
  logic        cpu_ce;
  logic        clk_sys;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  modport slave (
    input  run_sw, step_btn, div_sel, cpu_halt,
    output cpu_ce, clk_sys, state, cycle_cnt
  );

  modport master (
    output run_sw, step_btn, div_sel, cpu_halt,
    input  cpu_ce, clk_sys, state, cycle_cnt
  );
endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter that accepts a new
// level after DEB_CYCLES consecutive differing samples, and a one-clk rise pulse.
module btn_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stab_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stab_cnt <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (stab_cnt == CMAX) begin
          level    <= sync2;
          stab_cnt <= '0;
          rise     <= sync2;
        end else begin
          stab_cnt <= stab_cnt + CW'(1);
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt sequencer producing a registered one-clk CPU clock enable, a
// display toggle and a count of issued enables.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV0       = DIV0_DEF,
  parameter int unsigned DIV1       = DIV1_DEF,
  parameter int unsigned DIV2       = DIV2_DEF,
  parameter int unsigned DIV3       = DIV3_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_clk_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIM0 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(DIV3 - 1);

  clk_state_t       state_q, state_nx;
  logic             cpu_ce_q, ce_nx;
  logic             clk_sys_q;
  logic [31:0]      cycle_cnt_q;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_nx;
  logic [CNT_W-1:0] lim;
  logic             deb_level, deb_rise, step_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.step_btn),
    .level   (deb_level),
    .rise    (deb_rise)
  );

  // rise is only ever raised together with the debounced level going high
  assign step_pulse = deb_rise & deb_level;

  always_comb begin
    lim = LIM0;
    case (bus.div_sel)
      2'd0:    lim = LIM0;
      2'd1:    lim = LIM1;
      2'd2:    lim = LIM2;
      default: lim = LIM3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cpu_ce_q    <= 1'b0;
      clk_sys_q   <= 1'b0;
      cycle_cnt_q <= '0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_nx;
      cpu_ce_q    <= ce_nx;
      clk_sys_q   <= clk_sys_q ^ ce_nx;
      cycle_cnt_q <= cycle_cnt_q + {31'b0, ce_nx};
      div_cnt_q   <= div_cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_halt)    state_nx = ST_HALTED;
        else if (bus.run_sw) state_nx = ST_RUN;
        else if (step_pulse) state_nx = ST_STEP;
      end
      ST_RUN: begin
        if (bus.cpu_halt)     state_nx = ST_HALTED;
        else if (!bus.run_sw) state_nx = ST_IDLE;
      end
      ST_STEP:   state_nx = ST_IDLE;
      ST_HALTED: begin
        if (!bus.cpu_halt && !bus.run_sw) state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Enable and divide counter are computed one cycle ahead so cpu_ce lands
  // together with the registered state.
  always_comb begin
    ce_nx      = 1'b0;
    div_cnt_nx = '0;
    case (state_q)
      ST_IDLE: ce_nx = !bus.cpu_halt && !bus.run_sw && step_pulse;
      ST_RUN: begin
        if (!bus.cpu_halt && bus.run_sw) begin
          if (div_cnt_q >= lim) ce_nx      = 1'b1;
          else                  div_cnt_nx = div_cnt_q + CNT_W'(1);
        end
      end
      default: ce_nx = 1'b0;
    endcase
  end

  assign bus.cpu_ce    = cpu_ce_q;
  assign bus.clk_sys   = clk_sys_q;
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomised and directed bench for cpu_clk_ctrl against a cycle-level reference model.
module tb_cpu_clk_ctrl;

  localparam int unsigned T_DIV0 = 4;
  localparam int unsigned T_DIV1 = 8;
  localparam int unsigned T_DIV2 = 2;
  localparam int unsigned T_DIV3 = 1;
  localparam int unsigned T_DEB  = 3;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cpu_clk_ctrl_if bus ();

  cpu_clk_ctrl #(
    .DIV0(T_DIV0), .DIV1(T_DIV1), .DIV2(T_DIV2), .DIV3(T_DIV3),
    .CNT_W(26), .DEB_CYCLES(T_DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_state;
  int          m_phase;
  bit          m_ce;
  bit          m_clk_sys;
  logic [31:0] m_cnt;
  bit          m_level;
  bit          m_rise;
  bit          raw_hist[$];
  bit          sync_run[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'd0:    return int'(T_DIV0);
      2'd1:    return int'(T_DIV1);
      2'd2:    return int'(T_DIV2);
      default: return int'(T_DIV3);
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_phase = 0; m_ce = 0; m_clk_sys = 0; m_cnt = '0;
    m_level = 0; m_rise = 0;
    raw_hist.delete(); sync_run.delete();
  endtask

  // One clock edge of the reference behaviour, using the inputs as presented at the edge.
  task automatic model_step();
    bit fire;
    bit s2;
    bit all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = 0;
    case (m_state)
      M_IDLE: begin
        if (bus.cpu_halt)    m_state = M_HALT;
        else if (bus.run_sw) begin m_state = M_RUN; m_phase = 0; end
        else if (m_rise)     begin m_state = M_STEP; fire = 1; end
      end
      M_RUN: begin
        if (bus.cpu_halt)     m_state = M_HALT;
        else if (!bus.run_sw) m_state = M_IDLE;
        else if (m_phase + 1 >= div_of(bus.div_sel)) begin fire = 1; m_phase = 0; end
        else m_phase++;
      end
      M_STEP: m_state = M_IDLE;
      default: if (!bus.cpu_halt && !bus.run_sw) m_state = M_IDLE;
    endcase
    m_ce = fire;
    if (fire) begin
      m_clk_sys = !m_clk_sys;
      m_cnt     = m_cnt + 32'd1;
    end
    // button path: sample seen two edges late, level flips after T_DEB differing samples
    s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
    raw_hist.push_back(bus.step_btn);
    if (raw_hist.size() > 2) void'(raw_hist.pop_front());
    sync_run.push_back(s2);
    if (sync_run.size() > T_DEB) void'(sync_run.pop_front());
    all_diff = (sync_run.size() == T_DEB);
    foreach (sync_run[i]) if (sync_run[i] == m_level) all_diff = 0;
    m_rise = 0;
    if (all_diff) begin
      m_level = !m_level;
      m_rise  = m_level;
      sync_run.delete();
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("state",     {30'b0, bus.state}, m_state);
    check("cpu_ce",    {31'b0, bus.cpu_ce}, {31'b0, m_ce});
    check("clk_sys",   {31'b0, bus.clk_sys}, {31'b0, m_clk_sys});
    check("cycle_cnt", bus.cycle_cnt, m_cnt);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},  {30'b0, bus.state}, 32'd0);
    check({tag, "_ce"},     {31'b0, bus.cpu_ce}, 32'd0);
    check({tag, "_clksys"}, {31'b0, bus.clk_sys}, 32'd0);
    check({tag, "_cnt"},    bus.cycle_cnt, 32'd0);
  endtask

  initial begin
    int steps;
    int ces;
    logic ck0;
    bit pattern[6];
    bus.run_sw = 0; bus.step_btn = 0; bus.div_sel = 2'd0; bus.cpu_halt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // free-run at DIV0
    bus.run_sw = 1;
    cycles(100);
    check("run100_cnt", bus.cycle_cnt, 32'd24);

    // bouncy press in IDLE -> one step
    bus.run_sw = 0;
    cycles(3);
    pattern = '{1, 0, 1, 0, 1, 1};
    steps = 0; ces = 0; ck0 = bus.clk_sys;
    for (int i = 0; i < 24; i++) begin
      bus.step_btn = (i < 6) ? pattern[i] : (i < 14);
      cycle();
      if (bus.state == 2'b10) steps++;
      if (bus.cpu_ce) ces++;
    end
    check("bounce_steps", steps, 32'd1);
    check("bounce_ces", ces, 32'd1);
    check("bounce_clksys", {31'b0, bus.clk_sys}, {31'b0, ~ck0});

    // div_sel 1 -> 2 with the counter already past the new limit
    bus.div_sel = 2'd1; bus.run_sw = 1;
    cycles(7);
    bus.div_sel = 2'd2;
    cycle();
    check("divchg_ce", {31'b0, bus.cpu_ce}, 32'd1);
    cycles(6);

    // halt on the terminal count cycle
    bus.run_sw = 0;
    cycle();
    bus.run_sw = 1; bus.div_sel = 2'd0;
    cycles(4);
    bus.cpu_halt = 1;
    cycle();
    check("halt_ce", {31'b0, bus.cpu_ce}, 32'd0);
    check("halt_state", {30'b0, bus.state}, 32'd3);
    bus.step_btn = 1; cycles(8);
    bus.step_btn = 0; cycles(8);
    bus.cpu_halt = 0;
    cycles(3);
    check("halt_hold", {30'b0, bus.state}, 32'd3);
    bus.run_sw = 0;
    cycle();
    check("halt_exit", {30'b0, bus.state}, 32'd0);

    // full speed and cycle counter wrap
    bus.run_sw = 1; bus.div_sel = 2'd3;
    cycles(5);
    check("full_ce", {31'b0, bus.cpu_ce}, 32'd1);
    force dut.cycle_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.cycle_cnt_q;
    m_cnt = 32'hFFFF_FFFD;
    cycles(3);
    check("wrap_cnt", bus.cycle_cnt, 32'd0);
    cycles(2);

    // asynchronous reset while cpu_ce is high
    rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    bus.run_sw = 0;
    cycles(2);
    #2 rst_n = 1'b1;
    cycles(4);
    check("arst_idle", {30'b0, bus.state}, 32'd0);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) bus.run_sw = ~bus.run_sw;
      if ($urandom_range(29, 0) == 0) bus.div_sel = 2'($urandom_range(3, 0));
      if ($urandom_range(199, 0) == 0) bus.cpu_halt = ~bus.cpu_halt;
      if ($urandom_range(7, 0) == 0) bus.step_btn = ~bus.step_btn;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
